slave_external: RTL and testbench

Serial bus slave: the responder end of the external master's control/data protocol. It sits on the shared `control`/`wrD`/`valid` lines and decodes serial control frames of the form START|SLAVE_ID|r/w|B|address. It services matching single-word and burst writes into a local memory, and returns read data serially on `rD`/`ready`.

---
 rtl/slave_pkg.sv | 26 ++
 rtl/slave_mem.sv | 23 ++
 rtl/slave_external.sv | 203 ++++++++++++++++++++
 tb/tb_slave_external.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/slave_pkg.sv
// rtl/slave_pkg.sv - shared widths, FSM state codes and control-frame layout for slave_external
package slave_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_ID_WIDTH   = 3;
    localparam int DEF_MEM_DEPTH  = 4096;
    localparam int DEF_BURST_LEN  = 4;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE       = 3'd0;
    localparam state_t S_CTRL       = 3'd1;
    localparam state_t S_WRITE      = 3'd2;
    localparam state_t S_READ_FETCH = 3'd3;
    localparam state_t S_READ       = 3'd4;

    // Field order matches the wire order of the frame, MSB first after the start bit.
    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic                      rw;
        logic                      burst;
        logic [DEF_ADDR_WIDTH-1:0] addr;
    } ctrl_frame_t;

endpackage

// File: rtl/slave_mem.sv
// rtl/slave_mem.sv - single-port synchronous RAM with one-cycle read latency
module slave_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 4096,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/slave_external.sv
// rtl/slave_external.sv - serial bus slave; SLAVE_PARITY_EN adds a frame parity bit and sticky parityErr
module slave_external
    import slave_pkg::*;
#(
    parameter int                  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                  ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                  ID_WIDTH   = DEF_ID_WIDTH,
    parameter logic [ID_WIDTH-1:0] SLAVE_ID   = ID_WIDTH'(1),
    parameter int                  MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int                  BURST_LEN  = DEF_BURST_LEN
) (
    input  logic clk,
    input  logic rstN,
    input  logic control,
    input  logic wrD,
    input  logic valid,
    output logic rD,
    output logic ready,
    output logic busy
`ifdef SLAVE_PARITY_EN
    ,
    output logic parityErr
`endif
);

`ifdef SLAVE_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int HDR_BITS   = ID_WIDTH + 2 + ADDR_WIDTH;
    localparam int FRAME_BITS = HDR_BITS + PAR_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int BC_W       = $clog2(DATA_WIDTH);
    localparam int WC_W       = $clog2(BURST_LEN + 1);

    state_t                  state;
    logic [FRAME_BITS-2:0]   ctrl_sr;
    logic [FRAME_BITS-1:0]   frame_full;
    logic [CNT_W-1:0]        ctrl_cnt;
    ctrl_frame_t             hdr;
    logic                    frame_ok;
    logic [ADDR_WIDTH-1:0]   start_addr;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    burst_q;
    logic [BC_W-1:0]         bit_cnt;
    logic [WC_W-1:0]         word_cnt;
    logic [WC_W-1:0]         last_word;
    logic [WC_W-1:0]         n_words;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    we;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   rdata;

    // The frame as it stands once the bit on `control` this cycle is shifted in.
    assign frame_full = {ctrl_sr, control};
    assign hdr        = frame_full[FRAME_BITS-1 -: HDR_BITS];
    assign start_addr = ADDR_WIDTH'(hdr.addr % MEM_DEPTH);
    assign last_word  = burst_q ? WC_W'(BURST_LEN - 1) : '0;
    assign n_words    = burst_q ? WC_W'(BURST_LEN) : WC_W'(1);

`ifdef SLAVE_PARITY_EN
    logic parity_ok;
    assign parity_ok = ~^frame_full;
    assign frame_ok  = parity_ok && (hdr.id == SLAVE_ID);
`else
    assign frame_ok  = (hdr.id == SLAVE_ID);
`endif

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    // A pending write commit owns the port for one cycle; otherwise it reads addr_q.
    assign mem_addr = we ? waddr : addr_q;

    slave_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .addr  (mem_addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            ready    <= 1'b0;
            rD       <= 1'b0;
            ctrl_sr  <= '0;
            ctrl_cnt <= '0;
            addr_q   <= '0;
            burst_q  <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            shift_q  <= '0;
            we       <= 1'b0;
            wdata    <= '0;
            waddr    <= '0;
`ifdef SLAVE_PARITY_EN
            parityErr <= 1'b0;
`endif
        end else begin
            we <= 1'b0;
            case (state)
                S_IDLE: begin
                    ready <= 1'b0;
                    rD    <= 1'b0;
                    if (control) begin
                        state    <= S_CTRL;
                        busy     <= 1'b1;
                        ctrl_cnt <= '0;
                    end
                end
                S_CTRL: begin
                    ctrl_sr <= frame_full[FRAME_BITS-2:0];
                    if (ctrl_cnt == CNT_W'(FRAME_BITS - 1)) begin
                        ctrl_cnt <= '0;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        burst_q  <= hdr.burst;
                        addr_q   <= start_addr;
`ifdef SLAVE_PARITY_EN
                        if (!parity_ok) begin
                            parityErr <= 1'b1;
                        end
`endif
                        if (!frame_ok) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else if (hdr.rw) begin
                            state <= S_READ_FETCH;
                        end else begin
                            state <= S_WRITE;
                        end
                    end else begin
                        ctrl_cnt <= ctrl_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (valid) begin
                        shift_q <= {shift_q[DATA_WIDTH-2:0], wrD};
                        if (bit_cnt == BC_W'(DATA_WIDTH - 1)) begin
                            bit_cnt  <= '0;
                            we       <= 1'b1;
                            wdata    <= {shift_q[DATA_WIDTH-2:0], wrD};
                            waddr    <= addr_q;
                            addr_q   <= next_addr(addr_q);
                            word_cnt <= word_cnt + 1'b1;
                            if (word_cnt == last_word) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_READ_FETCH: begin
                    state <= S_READ;
                end
                S_READ: begin
                    // Each word load advances addr_q so the next word is fetched while this one shifts out.
                    if (bit_cnt == '0) begin
                        if (word_cnt == n_words) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            ready <= 1'b0;
                            rD    <= 1'b0;
                        end else begin
                            ready   <= 1'b1;
                            rD      <= rdata[DATA_WIDTH-1];
                            shift_q <= {rdata[DATA_WIDTH-2:0], 1'b0};
                            addr_q  <= next_addr(addr_q);
                            bit_cnt <= BC_W'(1);
                        end
                    end else begin
                        rD      <= shift_q[DATA_WIDTH-1];
                        shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                        if (bit_cnt == BC_W'(DATA_WIDTH - 1)) begin
                            bit_cnt  <= '0;
                            word_cnt <= word_cnt + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_external.sv
// tb/tb_slave_external.sv - directed self-checking bench for slave_external (SLAVE_PARITY_EN aware)
module tb_slave_external;

    logic clk = 1'b0;
    logic rstN;
    logic control;
    logic wrD;
    logic valid;
    logic rD;
    logic ready;
    logic busy;
`ifdef SLAVE_PARITY_EN
    logic parityErr;
    logic par_flip;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    slave_external dut (
        .clk     (clk),
        .rstN    (rstN),
        .control (control),
        .wrD     (wrD),
        .valid   (valid),
        .rD      (rD),
        .ready   (ready),
        .busy    (busy)
`ifdef SLAVE_PARITY_EN
        ,
        .parityErr (parityErr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start bit, then ID, r/w, B, address MSB first; returns on the negedge after the last frame bit's edge.
    task automatic send_frame(input logic [2:0] id, input logic rw, input logic b, input logic [11:0] addr);
        logic [16:0] hdr;
        hdr = {id, rw, b, addr};
        @(negedge clk);
        control = 1'b1;
        for (int i = 16; i >= 0; i--) begin
            @(negedge clk);
            control = hdr[i];
        end
`ifdef SLAVE_PARITY_EN
        @(negedge clk);
        control = (^hdr) ^ par_flip;
`endif
        @(negedge clk);
        control = 1'b0;
    endtask

    // Shifts one word; gap_after >= 0 inserts gap_len cycles of valid=0 after that bit index.
    task automatic send_word(input logic [7:0] w, input int gap_after, input int gap_len, output logic busy_dropped);
        busy_dropped = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            valid = 1'b1;
            wrD   = w[i];
            if (7 - i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    valid = 1'b0;
                    wrD   = ~w[i];
                    if (!busy) busy_dropped = 1'b1;
                end
            end
        end
    endtask

    task automatic end_write(input string tag);
        @(negedge clk);
        valid = 1'b0;
        wrD   = 1'b0;
        check({tag, "_busy_end"}, busy, 1'b0);
    endtask

    task automatic do_read(input string tag, input logic [11:0] addr, input logic b, input int n,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_w [4];
        logic [7:0] word;
        int ready_cnt;
        exp_w = '{e0, e1, e2, e3};
        ready_cnt = 0;
        send_frame(3'd1, 1'b1, b, addr);
        check({tag, "_lat0"}, ready, 1'b0);
        @(negedge clk);
        check({tag, "_lat1"}, ready, 1'b0);
        for (int w = 0; w < n; w++) begin
            word = '0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                word = {word[6:0], rD};
                if (ready) ready_cnt++;
            end
            check($sformatf("%s_word%0d", tag, w), word, exp_w[w]);
        end
        check({tag, "_ready_cnt"}, ready_cnt, n * 8);
        @(negedge clk);
        check({tag, "_ready_end"}, ready, 1'b0);
        check({tag, "_busy_end"}, busy, 1'b0);
    endtask

    initial begin
        logic bd;
        logic ready_any;
        logic busy_any;
        rstN    = 1'b0;
        control = 1'b0;
        wrD     = 1'b0;
        valid   = 1'b0;
`ifdef SLAVE_PARITY_EN
        par_flip = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_rD", rD, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_busy", busy, 1'b0);
`ifdef SLAVE_PARITY_EN
        check("rst_parityErr", parityErr, 1'b0);
`endif
        rstN = 1'b1;

        // Single write then readback: A5 -> 1,0,1,0,0,1,0,1.
        send_frame(3'd1, 1'b0, 1'b0, 12'h005);
        check("wr1_busy", busy, 1'b1);
        send_word(8'hA5, -1, 0, bd);
        end_write("wr1");
        do_read("rd1", 12'h005, 1'b0, 1, 8'hA5, 8'h00, 8'h00, 8'h00);

        // Burst write across the top of memory and burst read back.
        send_frame(3'd1, 1'b0, 1'b1, 12'hFFE);
        send_word(8'h11, -1, 0, bd);
        send_word(8'h22, -1, 0, bd);
        send_word(8'h33, -1, 0, bd);
        send_word(8'h44, -1, 0, bd);
        end_write("bwr");
        do_read("brd", 12'hFFE, 1'b1, 4, 8'h11, 8'h22, 8'h33, 8'h44);
        do_read("wrap0", 12'h000, 1'b0, 1, 8'h33, 8'h00, 8'h00, 8'h00);
        do_read("wrap1", 12'h001, 1'b0, 1, 8'h44, 8'h00, 8'h00, 8'h00);

        // Gapped valid: five idle cycles after bit index 3.
        send_frame(3'd1, 1'b0, 1'b0, 12'h010);
        send_word(8'h3C, 3, 5, bd);
        check("gap_busy_hold", bd, 1'b0);
        end_write("gap");
        do_read("gaprd", 12'h010, 1'b0, 1, 8'h3C, 8'h00, 8'h00, 8'h00);

        // Frame for another slave: no response, data pulses ignored.
        send_frame(3'd2, 1'b0, 1'b0, 12'h005);
        check("idm_busy", busy, 1'b0);
        ready_any = 1'b0;
        busy_any  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            valid = 1'b1;
            wrD   = 1'b0;
            ready_any |= ready;
            busy_any  |= busy;
        end
        @(negedge clk);
        valid = 1'b0;
        check("idm_ready", ready_any, 1'b0);
        check("idm_busy_any", busy_any, 1'b0);
        do_read("idmrd", 12'h005, 1'b0, 1, 8'hA5, 8'h00, 8'h00, 8'h00);

        // Reset during the third read bit of A5 (bit value 1).
        send_frame(3'd1, 1'b1, 1'b0, 12'h005);
        repeat (4) @(negedge clk);
        check("rst_mid_pre_ready", ready, 1'b1);
        check("rst_mid_pre_rD", rD, 1'b1);
        rstN = 1'b0;
        #1;
        check("rst_mid_ready", ready, 1'b0);
        check("rst_mid_rD", rD, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        do_read("postrst", 12'h010, 1'b0, 1, 8'h3C, 8'h00, 8'h00, 8'h00);

`ifdef SLAVE_PARITY_EN
        send_frame(3'd1, 1'b0, 1'b0, 12'h020);
        send_word(8'h5A, -1, 0, bd);
        end_write("pwr");
        check("par_ok_err", parityErr, 1'b0);
        par_flip = 1'b1;
        send_frame(3'd1, 1'b0, 1'b0, 12'h020);
        par_flip = 1'b0;
        check("par_bad_busy", busy, 1'b0);
        check("par_bad_err", parityErr, 1'b1);
        send_word(8'h77, -1, 0, bd);
        @(negedge clk);
        valid = 1'b0;
        do_read("parrd", 12'h020, 1'b0, 1, 8'h5A, 8'h00, 8'h00, 8'h00);
        check("par_sticky", parityErr, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
